// File: rtl/trdb_pkg.sv
// trdb_pkg: shared constants and enums for the trace debug encoder filter path
package trdb_pkg;
   localparam int unsigned XLEN = 32;
   typedef enum logic [1:0] {
      RANGE_WINDOW = 2'b00,
      RANGE_START  = 2'b01,
      RANGE_STOP   = 2'b10,
      RANGE_RSVD   = 2'b11
   } range_kind_e;
   typedef enum logic {
      F_OFF = 1'b0,
      F_ON  = 1'b1
   } filter_state_e;
endpackage

// File: rtl/trdb_range_cmp.sv
// trdb_range_cmp: inclusive unsigned address comparator; lower > upper never hits
module trdb_range_cmp #(
   parameter int unsigned XLEN = 32
) (
   input  logic            en_i,
   input  logic [XLEN-1:0] lower_i,
   input  logic [XLEN-1:0] upper_i,
   input  logic [XLEN-1:0] iaddr_i,
   output logic            hit_o
);
   assign hit_o = en_i && (lower_i <= iaddr_i) && (iaddr_i <= upper_i);
endmodule

// File: rtl/trdb_filter_ctrl.sv
// trdb_filter_ctrl: ON/OFF trace state machine with address ranges, privilege
// filter and stop-after-N counter; produces registered per-instruction qualification
module trdb_filter_ctrl #(
   parameter int unsigned XLEN       = trdb_pkg::XLEN,
   parameter int unsigned NUM_RANGES = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            trace_activated_i,
   input  logic                            trigger_trace_on_i,
   input  logic                            trigger_trace_off_i,
   input  logic                            apply_filters_i,
   input  logic                            iretire_i,
   input  logic [XLEN-1:0]                 iaddr_i,
   input  logic [1:0]                      priv_lvl_i,
   input  logic                            trace_selected_priv_i,
   input  logic [1:0]                      which_priv_i,
   input  logic [NUM_RANGES-1:0]           range_en_i,
   input  logic [NUM_RANGES-1:0][1:0]      range_kind_i,
   input  logic [NUM_RANGES-1:0][XLEN-1:0] range_lower_i,
   input  logic [NUM_RANGES-1:0][XLEN-1:0] range_upper_i,
   input  logic [CNT_W-1:0]                stop_count_i,
   output logic                            trace_qualified_o,
   output logic                            trace_range_match_o,
   output logic                            trace_priv_match_o,
   output logic                            trace_req_deactivate_o,
   output logic                            trace_on_o
);
   import trdb_pkg::*;
   logic [NUM_RANGES-1:0] hit, win_en, win_hit, start_v, stop_v;
   for (genvar k = 0; k < NUM_RANGES; k++) begin : g_rng
      trdb_range_cmp #(.XLEN(XLEN)) u_cmp (
         .en_i    (range_en_i[k]),
         .lower_i (range_lower_i[k]),
         .upper_i (range_upper_i[k]),
         .iaddr_i (iaddr_i),
         .hit_o   (hit[k])
      );
      assign win_en[k]  = range_en_i[k] && (range_kind_i[k] == RANGE_WINDOW);
      assign win_hit[k] = hit[k] && (range_kind_i[k] == RANGE_WINDOW);
      assign start_v[k] = hit[k] && (range_kind_i[k] == RANGE_START);
      assign stop_v[k]  = hit[k] && (range_kind_i[k] == RANGE_STOP);
   end
   filter_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic qual_q, qual_d, rmatch_q, rmatch_d, pmatch_q, pmatch_d, deact_q, deact_d;
   logic win_match, priv_match, filt_ok, start_hit, stop_hit, is_on;
   logic cnt_expire, stop_req, go_on, go_off;
   always_comb begin
      win_match  = (|win_hit) || !(|win_en);
      priv_match = !trace_selected_priv_i || (priv_lvl_i == which_priv_i);
      filt_ok    = !apply_filters_i || (win_match && priv_match);
      start_hit  = iretire_i && apply_filters_i && (|start_v);
      stop_hit   = iretire_i && apply_filters_i && (|stop_v);
      is_on      = state_q == F_ON;
      cnt_expire = is_on && (stop_count_i != '0) && iretire_i && filt_ok &&
                   (cnt_q == stop_count_i - CNT_W'(1));
      stop_req   = trigger_trace_off_i || stop_hit || cnt_expire;
      go_on      = !is_on && trace_activated_i && (trigger_trace_on_i || start_hit) &&
                   !trigger_trace_off_i;
      go_off     = is_on && (!trace_activated_i || stop_req);
      state_d    = go_on ? F_ON : go_off ? F_OFF : state_q;
      cnt_d      = go_on ? '0 :
                   (is_on && iretire_i && filt_ok && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
      qual_d     = iretire_i && trace_activated_i && filt_ok && !trigger_trace_off_i &&
                   (is_on || go_on);
      rmatch_d   = win_match;
      pmatch_d   = priv_match;
      // a drop of trace_activated already clears the register, so no request
      deact_d    = is_on && trace_activated_i && stop_req;
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= F_OFF;
         cnt_q    <= '0;
         qual_q   <= 1'b0;
         rmatch_q <= 1'b0;
         pmatch_q <= 1'b0;
         deact_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         qual_q   <= qual_d;
         rmatch_q <= rmatch_d;
         pmatch_q <= pmatch_d;
         deact_q  <= deact_d;
      end
   end
   assign trace_qualified_o      = qual_q;
   assign trace_range_match_o    = rmatch_q;
   assign trace_priv_match_o     = pmatch_q;
   assign trace_req_deactivate_o = deact_q;
   assign trace_on_o             = state_q == F_ON;
endmodule

// File: tb/tb_trdb_filter_ctrl.sv
// tb_trdb_filter_ctrl: vector table, directed corner sequences and random
// stimulus checked against a behavioural model of the filter rules
module tb_trdb_filter_ctrl;
   localparam int NR = 4;
   localparam int CW = 16;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n, act, ton, toff, apply, ret, sel;
   logic [31:0] iaddr;
   logic [1:0] priv, which;
   logic [NR-1:0] ren;
   logic [NR-1:0][1:0] rkind;
   logic [NR-1:0][31:0] rlo, rhi;
   logic [CW-1:0] stop;
   logic q, rm, pm, dz, on;
   int compared = 0, mismatched = 0;
   bit m_on;
   int m_cnt;
   typedef struct packed {
      logic       a, t1, t0, r;
      logic [4:0] exp;
   } vec_t;
   vec_t tbl [12];

   trdb_filter_ctrl #(.XLEN(32), .NUM_RANGES(NR), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .trace_activated_i(act),
      .trigger_trace_on_i(ton), .trigger_trace_off_i(toff),
      .apply_filters_i(apply), .iretire_i(ret), .iaddr_i(iaddr),
      .priv_lvl_i(priv), .trace_selected_priv_i(sel), .which_priv_i(which),
      .range_en_i(ren), .range_kind_i(rkind), .range_lower_i(rlo),
      .range_upper_i(rhi), .stop_count_i(stop),
      .trace_qualified_o(q), .trace_range_match_o(rm), .trace_priv_match_o(pm),
      .trace_req_deactivate_o(dz), .trace_on_o(on)
   );

   task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got {q,rm,pm,deact,on}=%b required %b at %0t", name, got, exp, $time);
      end
   endtask

   // expected {q,rm,pm,deact,on} after the coming edge; advances model state
   task automatic model(output logic [4:0] e);
      bit any_w = 0, w = 0, st = 0, sp = 0, pmx, fo, ex, nx, qx, dx;
      if (!rst_n) begin
         m_on = 0;
         m_cnt = 0;
         e = '0;
         return;
      end
      for (int k = 0; k < NR; k++) begin
         bit h;
         h = ren[k] && rlo[k] <= iaddr && iaddr <= rhi[k];
         if (ren[k] && rkind[k] == 2'd0) any_w = 1;
         if (h && rkind[k] == 2'd0) w = 1;
         if (h && rkind[k] == 2'd1) st = 1;
         if (h && rkind[k] == 2'd2) sp = 1;
      end
      if (!any_w) w = 1;
      pmx = !sel || priv == which;
      fo = !apply || (w && pmx);
      st = st && ret && apply;
      sp = sp && ret && apply;
      ex = m_on && stop != 0 && ret && fo && m_cnt == int'(stop) - 1;
      nx = m_on ? (act && !toff && !sp && !ex) : (act && (ton || st) && !toff);
      qx = ret && act && fo && !toff && (m_on || nx);
      dx = m_on && !nx && act;
      if (!m_on && nx) m_cnt = 0;
      else if (m_on && ret && fo && m_cnt < (1 << CW) - 1) m_cnt++;
      m_on = nx;
      e = {qx, w, pmx, dx, nx};
   endtask

   task automatic step(input string name);
      logic [4:0] e;
      model(e);
      @(posedge clk);
      #1;
      check(name, {q, rm, pm, dz, on}, e);
   endtask

   task automatic idle();
      rst_n = 1; act = 1; ton = 0; toff = 0; ret = 0;
   endtask

   initial begin
      rst_n = 0; act = 0; ton = 0; toff = 0; apply = 0; ret = 0; sel = 0;
      iaddr = '0; priv = '0; which = '0; ren = '0; rkind = '0; rlo = '0; rhi = '0; stop = '0;
      step("reset");
      check("reset_state", {q, rm, pm, dz, on}, 5'b00000);
      tbl[0]  = 9'b1001_01100;
      tbl[1]  = 9'b1101_11101;
      tbl[2]  = 9'b1001_11101;
      tbl[3]  = 9'b1000_01101;
      tbl[4]  = 9'b1011_01110;
      tbl[5]  = 9'b1111_01100;
      tbl[6]  = 9'b1100_01101;
      tbl[7]  = 9'b1111_01110;
      tbl[8]  = 9'b1101_11101;
      tbl[9]  = 9'b0001_01100;
      tbl[10] = 9'b0101_01100;
      tbl[11] = 9'b1001_01100;
      for (int i = 0; i < 12; i++) begin
         rst_n = 1; act = tbl[i].a; ton = tbl[i].t1; toff = tbl[i].t0; ret = tbl[i].r;
         step("tbl_model");
         check($sformatf("tbl_vec%0d", i), {q, rm, pm, dz, on}, tbl[i].exp);
      end
      // reset while ON
      idle(); ton = 1; step("pre_rst_on");
      idle(); rst_n = 0; ret = 1; step("rst_mid_on");
      check("rst_mid_on_outs", {q, rm, pm, dz, on}, 5'b00000);
      idle(); step("after_rst");
      check("after_rst_no_pulse", {dz, on}, 2'b00);
      // window filter
      ren = 4'b0001; rkind[0] = 2'd0; rlo[0] = 32'h1000; rhi[0] = 32'h1FFF; apply = 1;
      idle(); ton = 1; step("win_on");
      idle(); ret = 1; iaddr = 32'h1FFF; step("win_in");
      check("win_in_q_rm", {q, rm, on}, 3'b111);
      idle(); ret = 1; iaddr = 32'h2000; step("win_out");
      check("win_out_q_rm", {q, rm, on}, 3'b001);
      // start / stop ranges
      idle(); toff = 1; step("ss_off");
      ren = 4'b0110; rkind[1] = 2'd1; rlo[1] = 32'h4000; rhi[1] = 32'h4000;
      rkind[2] = 2'd2; rlo[2] = 32'h5000; rhi[2] = 32'h5000;
      idle(); step("ss_idle");
      idle(); ret = 1; iaddr = 32'h4000; step("ss_start");
      check("start_traced", {q, dz, on}, 3'b101);
      idle(); ret = 1; iaddr = 32'h4800; step("ss_mid");
      idle(); ret = 1; iaddr = 32'h5000; step("ss_stop");
      check("stop_traced_pulse", {q, dz, on}, 3'b110);
      idle(); step("ss_after");
      check("pulse_one_cycle", {dz, on}, 2'b00);
      // stop counter
      ren = '0; apply = 0; stop = 16'd3;
      idle(); ton = 1; step("cnt_on");
      for (int i = 0; i < 3; i++) begin
         idle(); ret = 1; step("cnt_ret");
      end
      check("cnt_third", {q, dz, on}, 3'b110);
      idle(); ret = 1; step("cnt_fourth");
      check("cnt_fourth_q", {q, on}, 2'b00);
      stop = '0;
      idle(); ton = 1; step("unl_on");
      for (int i = 0; i < 70000; i++) begin
         idle(); ret = 1; step("unlimited");
      end
      check("unlimited_still_on", {q, on}, 2'b11);
      // privilege filter
      apply = 1; sel = 1; which = 2'b11;
      for (int i = 0; i < 6; i++) begin
         idle(); ret = 1; priv = i[0] ? 2'b11 : 2'b00; step("priv");
         check("priv_q_pm", {q, pm}, i[0] ? 2'b11 : 2'b00);
      end
      sel = 0; apply = 0;
      // simultaneous triggers / activated drop
      idle(); toff = 1; step("sim_pre");
      idle(); ton = 1; toff = 1; ret = 1; step("sim_off_both");
      check("both_in_off", {q, dz, on}, 3'b000);
      idle(); ton = 1; step("sim_go_on");
      idle(); ton = 1; toff = 1; ret = 1; step("sim_on_both");
      check("both_in_on", {q, dz, on}, 3'b010);
      idle(); ton = 1; step("drop_pre");
      idle(); act = 0; ret = 1; step("drop");
      check("drop_no_pulse", {q, dz, on}, 3'b000);
      // random
      for (int i = 0; i < 3000; i++) begin
         if (i % 50 == 0) begin
            for (int k = 0; k < NR; k++) begin
               rkind[k] = 2'($urandom_range(0, 3));
               rlo[k] = 32'($urandom_range(0, 63));
               rhi[k] = 32'($urandom_range(0, 63));
            end
            ren = 4'($urandom);
            stop = 16'($urandom_range(0, 4));
            which = 2'($urandom);
         end
         rst_n = $urandom_range(0, 199) != 0;
         act = $urandom_range(0, 19) != 0;
         ton = $urandom_range(0, 7) == 0;
         toff = $urandom_range(0, 11) == 0;
         apply = $urandom_range(0, 3) != 0;
         ret = $urandom_range(0, 3) != 0;
         sel = 1'($urandom);
         priv = 2'($urandom);
         iaddr = 32'($urandom_range(0, 63));
         step("random");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/trdb_filter_ctrl.md
Name: trdb_filter_ctrl

Overview:
Parametrised successor to the trace-encoder on/off filter. Adds a registered ON/OFF tracing state machine driven by trigger events, NUM_RANGES programmable address comparators (window, start or stop kind), a privilege filter and a stop-after-N-retirements counter. Sits between the register file / trigger unit and the encoder core, and produces the per-instruction trace qualification.

Parameters:
XLEN, 32, instruction address width (default for the trdb_pkg constant).
NUM_RANGES, 4, number of address comparators (1..8).
CNT_W, 16, width of the retirement stop counter.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset, synchronous, active-low.
trace_activated_i  in  1  global enable from registers.
trigger_trace_on_i  in  1  trigger unit start event.
trigger_trace_off_i  in  1  trigger unit stop event.
apply_filters_i  in  1  1 = apply range and priv filters.
iretire_i  in  1  valid retired instruction this cycle.
iaddr_i  in  XLEN  address of retired instruction.
priv_lvl_i  in  2  privilege of retired instruction.
trace_selected_priv_i  in  1  enable privilege filter.
which_priv_i  in  2  selected privilege.
range_en_i  in  NUM_RANGES  per-range enable.
range_kind_i  in  NUM_RANGES x 2  per-range kind: 00 window, 01 start, 10 stop, 11 reserved (ignored).
range_lower_i  in  NUM_RANGES x XLEN  inclusive lower bound.
range_upper_i  in  NUM_RANGES x XLEN  inclusive upper bound.
stop_count_i  in  CNT_W  stop after N qualified retirements; 0 = unlimited.
trace_qualified_o  out  1  instruction qualified for tracing (registered).
trace_range_match_o  out  1  window match (registered).
trace_priv_match_o  out  1  priv match (registered).
trace_req_deactivate_o  out  1  one-cycle pulse requesting a register clear of trace_activated.
trace_on_o  out  1  FSM state (1 = ON).

Behaviour:
- Reset (rst_ni=0 at a clock edge): FSM OFF, counter 0, all outputs 0.
- hit_k = range_en_i[k] && lower_k <= iaddr_i <= upper_k (unsigned). lower > upper never hits.
- win_match = OR of window-kind hits; win_match = 1 if no enabled window range.
- start_hit / stop_hit = iretire_i && apply_filters_i && OR of start-/stop-kind hits.
- priv_match = !trace_selected_priv_i || priv_lvl_i == which_priv_i.
- filt_ok = !apply_filters_i || (win_match && priv_match).
- cnt_expire = ON && stop_count_i != 0 && iretire_i && filt_ok && counter == stop_count_i-1.
- FSM:
  - OFF -> ON: trace_activated_i && (trigger_trace_on_i || start_hit) && !trigger_trace_off_i.
  - ON -> OFF: !trace_activated_i, trigger_trace_off_i, stop_hit or cnt_expire.
  - on and off triggers in the same cycle: off wins in both states.
- Counter: cleared on OFF->ON. Increments on each iretire_i && filt_ok while ON. Saturates; never wraps.
- qual_d = iretire_i && trace_activated_i && filt_ok && !trigger_trace_off_i && (ON || OFF->ON transition this cycle).
  - The start-hit instruction is traced; the stop-hit and Nth instructions are traced; an off-trigger cycle is not.
- Latency: trace_qualified_o, trace_range_match_o and trace_priv_match_o are registered one cycle after the inputs.
- trace_req_deactivate_o: one-cycle pulse on any ON->OFF transition except one caused by !trace_activated_i. Registered, 1 cycle.
- trace_activated_i low forces OFF next cycle, with no pulse.
- Reset mid-ON: immediate OFF, counter cleared, no pulse.

Decomposition:
- trdb_pkg gains: XLEN (if absent); range_kind_e {RANGE_WINDOW, RANGE_START, RANGE_STOP, RANGE_RSVD}; filter_state_e {F_OFF, F_ON}.
- One sub-module, trdb_range_cmp: a single combinational comparator (lower/upper/iaddr/en -> hit), instantiated NUM_RANGES times via generate.

Test Plan:
- Reset/on-trigger: apply_filters=0, activated=1, pulse trigger_on with iretire=1 -> qualified=1 next cycle, trace_on_o=1; reset mid-ON -> all outputs 0, no deactivate pulse.
- Window filter: range0 window 0x1000..0x1FFF, apply=1, ON; iaddr 0x1FFF -> qualified 1, range_match 1; iaddr 0x2000 -> qualified 0, range_match 0.
- Start/stop ranges: range1 start at 0x4000, range2 stop at 0x5000; retire 0x4000 -> ON, that instruction qualified; retire 0x5000 -> qualified 1, then OFF and deactivate pulse for exactly 1 cycle.
- Counter: stop_count=3, ON, 3 qualified retirements -> third is qualified, FSM OFF, pulse; a 4th retirement is not qualified; stop_count=0 -> never expires after 70000 retirements.
- Priv filter: selected=1, which=2'b11, priv_lvl alternating 00/11 -> qualified only on 11 cycles; priv_match tracks with 1-cycle latency.
- Simultaneous events: trigger_on and trigger_off together in OFF -> stays OFF; in ON -> OFF, pulse, cycle not qualified; activated dropped while ON -> OFF, no pulse.
